// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: bus widths, access-size encodings,
// FSM state encoding and the byte-count helper.
package mem_access_pkg;

   localparam int unsigned RegBus     = 32;
   localparam int unsigned RegAddrBus = 5;
   localparam int unsigned MemAddrBus = 32;
   localparam int unsigned MemSelBus  = 2;

   localparam logic RstEnable = 1'b1;

   // Access-size encodings carried on mem_sel
   localparam logic [MemSelBus-1:0] MEM_NOP  = 2'd0;
   localparam logic [MemSelBus-1:0] MEM_BYTE = 2'd1;
   localparam logic [MemSelBus-1:0] MEM_HALF = 2'd2;
   localparam logic [MemSelBus-1:0] MEM_WORD = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } mem_state_e;

   // Number of byte transactions for an access size
   function automatic logic [2:0] sel_nbytes(input logic [MemSelBus-1:0] sel);
      case (sel)
         MEM_BYTE: return 3'd1;
         MEM_HALF: return 3'd2;
         MEM_WORD: return 3'd4;
         default:  return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_ext.sv
// load_ext: sign/zero extension of the assembled little-endian load buffer.
// Ports:
//   rbuf_i  - assembled read bytes (lane 0 = lowest address)
//   sel_i   - access size (byte/half/word)
//   sign_i  - 1 = sign-extend
//   ext_o   - 32-bit extended load result
module load_ext
   import mem_access_pkg::*;
(
   input  logic [RegBus-1:0]    rbuf_i,
   input  logic [MemSelBus-1:0] sel_i,
   input  logic                 sign_i,
   output logic [RegBus-1:0]    ext_o
);

   always_comb begin
      ext_o = rbuf_i;
      case (sel_i)
         MEM_BYTE: ext_o = {{24{sign_i & rbuf_i[7]}},  rbuf_i[7:0]};
         MEM_HALF: ext_o = {{16{sign_i & rbuf_i[15]}}, rbuf_i[15:0]};
         default:  ext_o = rbuf_i;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage. Splits loads/stores into byte transactions
// on a request/grant/response port, stalls the pipeline until the access
// completes, then presents the (extended) load result or ALU result to MEM/WB.
// Ports:
//   clk, rst                 - clock, async active-high reset
//   mem_rd/mem_wreg/mem_wdata - EX/MEM destination, write enable, ALU result
//   mem_addr/mem_reg2         - byte address, store data
//   mem_sel/mem_we/load_sign  - access size, store flag, sign-extend flag
//   hold                      - MEM/WB stalled
//   mc_req/mc_addr/mc_we/mc_wdata - registered byte request to memory controller
//   mc_gnt/mc_rvalid/mc_rdata     - grant and in-order read byte return
//   stall_req                 - pipeline stall request
//   wb_rd/wb_wreg/wb_wdata    - outputs to MEM/WB
module mem_access
   import mem_access_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [RegAddrBus-1:0] mem_rd,
   input  logic                  mem_wreg,
   input  logic [RegBus-1:0]     mem_wdata,
   input  logic [MemAddrBus-1:0] mem_addr,
   input  logic [RegBus-1:0]     mem_reg2,
   input  logic [MemSelBus-1:0]  mem_sel,
   input  logic                  mem_we,
   input  logic                  load_sign,
   input  logic                  hold,
   output logic                  mc_req,
   output logic [MemAddrBus-1:0] mc_addr,
   output logic                  mc_we,
   output logic [7:0]            mc_wdata,
   input  logic                  mc_gnt,
   input  logic                  mc_rvalid,
   input  logic [7:0]            mc_rdata,
   output logic                  stall_req,
   output logic [RegAddrBus-1:0] wb_rd,
   output logic                  wb_wreg,
   output logic [RegBus-1:0]     wb_wdata
);

   mem_state_e            state_q, state_d;
   logic [MemAddrBus-1:0] addr_q, addr_d;
   logic [2:0]            nbytes_q, nbytes_d;
   logic [2:0]            issued_q, issued_d;
   logic [2:0]            received_q, received_d;
   logic [MemSelBus-1:0]  sel_q, sel_d;
   logic                  we_q, we_d;
   logic                  sign_q, sign_d;
   logic [RegBus-1:0]     sdata_q, sdata_d;
   logic [RegBus-1:0]     rbuf_q, rbuf_d;
   logic                  mc_req_q, mc_req_d;
   logic [MemAddrBus-1:0] mc_addr_q, mc_addr_d;
   logic                  mc_we_q, mc_we_d;
   logic [7:0]            mc_wdata_q, mc_wdata_d;
   logic [RegBus-1:0]     ext_data;

   load_ext u_load_ext (
      .rbuf_i (rbuf_q),
      .sel_i  (sel_q),
      .sign_i (sign_q),
      .ext_o  (ext_data)
   );

   // State and registered request port
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RstEnable) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         nbytes_q   <= '0;
         issued_q   <= '0;
         received_q <= '0;
         sel_q      <= MEM_NOP;
         we_q       <= 1'b0;
         sign_q     <= 1'b0;
         sdata_q    <= '0;
         rbuf_q     <= '0;
         mc_req_q   <= 1'b0;
         mc_addr_q  <= '0;
         mc_we_q    <= 1'b0;
         mc_wdata_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         nbytes_q   <= nbytes_d;
         issued_q   <= issued_d;
         received_q <= received_d;
         sel_q      <= sel_d;
         we_q       <= we_d;
         sign_q     <= sign_d;
         sdata_q    <= sdata_d;
         rbuf_q     <= rbuf_d;
         mc_req_q   <= mc_req_d;
         mc_addr_q  <= mc_addr_d;
         mc_we_q    <= mc_we_d;
         mc_wdata_q <= mc_wdata_d;
      end
   end

   // Next-state, request sequencing and MEM/WB outputs
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      nbytes_d   = nbytes_q;
      issued_d   = issued_q;
      received_d = received_q;
      sel_d      = sel_q;
      we_d       = we_q;
      sign_d     = sign_q;
      sdata_d    = sdata_q;
      rbuf_d     = rbuf_q;
      mc_req_d   = mc_req_q;
      mc_addr_d  = mc_addr_q;
      mc_we_d    = mc_we_q;
      mc_wdata_d = mc_wdata_q;
      stall_req  = 1'b0;
      wb_rd      = '0;
      wb_wreg    = 1'b0;
      wb_wdata   = '0;

      // Returned bytes fill lanes in order; responses outside an access are dropped
      if ((state_q == ST_ISSUE || state_q == ST_WAIT) && mc_rvalid) begin
         rbuf_d[{received_q[1:0], 3'b000} +: 8] = mc_rdata;
         received_d = received_q + 3'd1;
      end

      case (state_q)
         ST_IDLE: begin
            if (mem_sel == MEM_NOP) begin
               wb_rd    = mem_rd;
               wb_wreg  = mem_wreg;
               wb_wdata = mem_wdata;
            end else begin
               stall_req  = 1'b1;
               addr_d     = mem_addr;
               nbytes_d   = sel_nbytes(mem_sel);
               sel_d      = mem_sel;
               we_d       = mem_we;
               sign_d     = load_sign;
               sdata_d    = mem_reg2;
               issued_d   = '0;
               received_d = '0;
               rbuf_d     = '0;
               mc_req_d   = 1'b1;
               mc_addr_d  = mem_addr;
               mc_we_d    = mem_we;
               mc_wdata_d = mem_reg2[7:0];
               state_d    = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            stall_req = 1'b1;
            if (mc_gnt) begin
               issued_d = issued_q + 3'd1;
               if (issued_d == nbytes_q) begin
                  mc_req_d = 1'b0;
                  // Last read byte may return in the same cycle as its grant
                  if (we_q || received_d == nbytes_q) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_WAIT;
                  end
               end else begin
                  // Present the next byte immediately for back-to-back issue
                  mc_addr_d  = addr_q + MemAddrBus'(issued_d);
                  mc_wdata_d = sdata_q[{issued_d[1:0], 3'b000} +: 8];
               end
            end
         end
         ST_WAIT: begin
            stall_req = 1'b1;
            if (received_d == nbytes_q) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            wb_rd    = mem_rd;
            wb_wreg  = mem_wreg;
            wb_wdata = we_q ? mem_wdata : ext_data;
            // Holding here keeps a stalled instruction from being re-executed
            if (!hold) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Combinational outputs read as idle/zero while reset is asserted
      if (rst == RstEnable) begin
         stall_req = 1'b0;
         wb_rd     = '0;
         wb_wreg   = 1'b0;
         wb_wdata  = '0;
      end
   end

   assign mc_req   = mc_req_q;
   assign mc_addr  = mc_addr_q;
   assign mc_we    = mc_we_q;
   assign mc_wdata = mc_wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: a byte-serial memory controller model
// with configurable grant gaps and read latency, plus scoreboards for the
// expected byte transactions and the expected MEM/WB result.
module tb_mem_access;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [7:0]  wdata;
   } mc_txn_t;

   typedef struct {
      int         due;
      logic [7:0] data;
   } rsp_t;

   logic        clk;
   logic        rst;
   logic [4:0]  mem_rd;
   logic        mem_wreg;
   logic [31:0] mem_wdata;
   logic [31:0] mem_addr;
   logic [31:0] mem_reg2;
   logic [1:0]  mem_sel;
   logic        mem_we;
   logic        load_sign;
   logic        hold;
   logic        mc_req;
   logic [31:0] mc_addr;
   logic        mc_we;
   logic [7:0]  mc_wdata;
   logic        mc_gnt;
   logic        mc_rvalid;
   logic [7:0]  mc_rdata;
   logic        stall_req;
   logic [4:0]  wb_rd;
   logic        wb_wreg;
   logic [31:0] wb_wdata;

   mc_txn_t     xq[$];
   rsp_t        rq[$];
   logic [31:0] exp_q[$];
   logic [7:0]  mem [logic [31:0]];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int gap      = 0;
   int lat      = 1;
   int n_gnt    = 0;

   mem_access dut (
      .clk       (clk),
      .rst       (rst),
      .mem_rd    (mem_rd),
      .mem_wreg  (mem_wreg),
      .mem_wdata (mem_wdata),
      .mem_addr  (mem_addr),
      .mem_reg2  (mem_reg2),
      .mem_sel   (mem_sel),
      .mem_we    (mem_we),
      .load_sign (load_sign),
      .hold      (hold),
      .mc_req    (mc_req),
      .mc_addr   (mc_addr),
      .mc_we     (mc_we),
      .mc_wdata  (mc_wdata),
      .mc_gnt    (mc_gnt),
      .mc_rvalid (mc_rvalid),
      .mc_rdata  (mc_rdata),
      .stall_req (stall_req),
      .wb_rd     (wb_rd),
      .wb_wreg   (wb_wreg),
      .wb_wdata  (wb_wdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Memory controller model: grants after 'gap' idle cycles, returns reads after 'lat'
   initial begin : mc_model
      int          wait_cnt;
      logic        prev_pend;
      logic [31:0] prev_addr;
      logic        prev_we;
      logic [7:0]  prev_wd;
      mc_txn_t     e;
      rsp_t        r;
      wait_cnt  = 0;
      prev_pend = 1'b0;
      prev_addr = '0;
      prev_we   = 1'b0;
      prev_wd   = '0;
      mc_gnt    = 1'b0;
      mc_rvalid = 1'b0;
      mc_rdata  = '0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         mc_gnt    = 1'b0;
         mc_rvalid = 1'b0;
         mc_rdata  = '0;
         if (rst) begin
            wait_cnt  = 0;
            prev_pend = 1'b0;
            continue;
         end
         if (prev_pend) begin
            chk("req_held", {mc_req, mc_addr, mc_we, mc_wdata}, {1'b1, prev_addr, prev_we, prev_wd});
         end
         prev_pend = 1'b0;
         if (mc_req) begin
            if (wait_cnt < gap) begin
               wait_cnt++;
               prev_pend = 1'b1;
               prev_addr = mc_addr;
               prev_we   = mc_we;
               prev_wd   = mc_wdata;
            end else begin
               wait_cnt = 0;
               mc_gnt   = 1'b1;
               n_gnt++;
               chk("mc_req_expected", 64'(xq.size() > 0), 64'd1);
               if (xq.size() > 0) begin
                  e = xq.pop_front();
                  chk("mc_addr", mc_addr, e.addr);
                  chk("mc_we", mc_we, e.we);
                  if (e.we) chk("mc_wdata", mc_wdata, e.wdata);
               end
               if (mc_we) begin
                  mem[mc_addr] = mc_wdata;
               end else begin
                  r.due  = cyc + lat;
                  r.data = mem.exists(mc_addr) ? mem[mc_addr] : 8'h00;
                  rq.push_back(r);
               end
            end
         end
         if (rq.size() > 0 && rq[0].due <= cyc) begin
            r = rq.pop_front();
            mc_rvalid = 1'b1;
            mc_rdata  = r.data;
         end
      end
   end

   // One access from presentation to DONE, optional hold, then a NOP pass-through
   task automatic run_op(input string nm, input logic [1:0] sel, input logic we, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] reg2, input logic [31:0] alu,
                         input logic [4:0] rd, input int g, input int l, input int hold_n,
                         input int exp_done, input logic [31:0] exp_val);
      int          n;
      int          done_c;
      logic [31:0] res;
      logic [31:0] nop_val;
      mc_txn_t     t;
      n = (sel == 2'd1) ? 1 : (sel == 2'd2) ? 2 : 4;
      @(posedge clk);
      #1;
      gap = g;
      lat = l;
      for (int i = 0; i < n; i++) begin
         t.addr  = addr + 32'(i);
         t.we    = we;
         t.wdata = we ? reg2[8*i +: 8] : 8'h00;
         xq.push_back(t);
      end
      exp_q.push_back(exp_val);
      hold      = (hold_n > 0);
      mem_sel   = sel;
      mem_we    = we;
      load_sign = sgn;
      mem_addr  = addr;
      mem_reg2  = reg2;
      mem_wdata = alu;
      mem_rd    = rd;
      mem_wreg  = 1'b1;
      done_c    = -1;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (!stall_req) begin
            done_c = c;
            break;
         end
      end
      chk({nm, "_stall_dropped"}, stall_req, 1'b0);
      res = exp_q.pop_front();
      chk({nm, "_wb_wdata"}, wb_wdata, res);
      chk({nm, "_wb_rd"}, wb_rd, rd);
      chk({nm, "_wb_wreg"}, wb_wreg, 1'b1);
      if (exp_done >= 0) chk({nm, "_done_cycle"}, 64'(done_c), 64'(exp_done));
      chk({nm, "_bytes_left"}, 64'(xq.size() + rq.size()), 64'd0);
      for (int k = 1; k < hold_n; k++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         chk({nm, "_hold_stall"}, stall_req, 1'b0);
         chk({nm, "_hold_req"}, mc_req, 1'b0);
         chk({nm, "_hold_wb"}, wb_wdata, res);
      end
      if (hold_n > 0) begin
         @(posedge clk);
         #1;
         hold = 1'b0;
         @(negedge clk);
         chk({nm, "_release_stall"}, stall_req, 1'b0);
      end
      @(posedge clk);
      #1;
      nop_val   = alu ^ 32'h5A5A_5A5A;
      mem_sel   = 2'd0;
      mem_wdata = nop_val;
      mem_rd    = rd + 5'd1;
      @(negedge clk);
      chk({nm, "_nop_wb"}, wb_wdata, nop_val);
      chk({nm, "_nop_rd"}, wb_rd, rd + 5'd1);
      chk({nm, "_nop_stall"}, stall_req, 1'b0);
      chk({nm, "_nop_req"}, mc_req, 1'b0);
   endtask

   initial begin : main
      mc_txn_t t;
      rsp_t    r;
      int      base;
      rst       = 1'b1;
      hold      = 1'b0;
      mem_sel   = 2'd0;
      mem_we    = 1'b0;
      load_sign = 1'b0;
      mem_addr  = 32'h0000_1234;
      mem_reg2  = 32'h0;
      mem_wdata = 32'h1111_2222;
      mem_wreg  = 1'b1;
      mem_rd    = 5'd3;
      #1;
      chk("rst_mc_req", mc_req, 1'b0);
      chk("rst_mc_addr", mc_addr, 32'h0);
      chk("rst_mc_we_wdata", {mc_we, mc_wdata}, 9'h0);
      chk("rst_stall", stall_req, 1'b0);
      chk("rst_wb", {wb_rd, wb_wreg, wb_wdata}, 38'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      mem[32'h0000_1000] = 8'h80;
      run_op("ldb_sign", 2'd1, 1'b0, 1'b1, 32'h0000_1000, 32'h0, 32'hAAAA_0001, 5'd4, 0, 1, 0, 3, 32'hFFFF_FF80);

      mem[32'h0000_2001] = 8'h34;
      mem[32'h0000_2002] = 8'h12;
      run_op("ldh_unal", 2'd2, 1'b0, 1'b0, 32'h0000_2001, 32'h0, 32'hAAAA_0002, 5'd5, 0, 1, 0, 4, 32'h0000_1234);

      run_op("stw_wrap", 2'd3, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'hDEAD_BEEF, 32'h1234_5678, 5'd6, 0, 1, 0, 5, 32'h1234_5678);
      chk("stw_wrap_mem0", mem[32'h0000_0000], 8'hAD);

      mem[32'h0000_3000] = 8'h11;
      mem[32'h0000_3001] = 8'h22;
      mem[32'h0000_3002] = 8'h33;
      mem[32'h0000_3003] = 8'h84;
      run_op("ldw_fast", 2'd3, 1'b0, 1'b1, 32'h0000_3000, 32'h0, 32'hAAAA_0004, 5'd7, 0, 1, 0, 6, 32'h8433_2211);

      mem[32'h0000_4002] = 8'h0D;
      mem[32'h0000_4003] = 8'hF0;
      mem[32'h0000_4004] = 8'hFE;
      mem[32'h0000_4005] = 8'hCA;
      run_op("ldw_slow", 2'd3, 1'b0, 1'b0, 32'h0000_4002, 32'h0, 32'hAAAA_0005, 5'd8, 2, 3, 0, 16, 32'hCAFE_F00D);

      mem[32'h0000_5000] = 8'hFE;
      mem[32'h0000_5001] = 8'hFF;
      run_op("ldh_lat0", 2'd2, 1'b0, 1'b1, 32'h0000_5000, 32'h0, 32'hAAAA_0006, 5'd9, 0, 0, 0, 3, 32'hFFFF_FFFE);

      mem[32'h0000_6000] = 8'h80;
      run_op("ldb_hold", 2'd1, 1'b0, 1'b0, 32'h0000_6000, 32'h0, 32'hAAAA_0007, 5'd10, 0, 2, 3, 4, 32'h0000_0080);

      run_op("stb_hold", 2'd1, 1'b1, 1'b0, 32'h0000_7000, 32'h0000_00AB, 32'h7777_0008, 5'd11, 0, 1, 3, 2, 32'h7777_0008);
      chk("stb_hold_mem", mem[32'h0000_7000], 8'hAB);

      // Async reset in the middle of a word store
      @(posedge clk);
      #1;
      gap  = 0;
      lat  = 1;
      base = n_gnt;
      for (int i = 0; i < 4; i++) begin
         t.addr  = 32'h0000_8000 + 32'(i);
         t.we    = 1'b1;
         t.wdata = 8'h11 * 8'(i + 1);
         xq.push_back(t);
      end
      mem_sel   = 2'd3;
      mem_we    = 1'b1;
      load_sign = 1'b0;
      mem_addr  = 32'h0000_8000;
      mem_reg2  = 32'h4433_2211;
      mem_wdata = 32'h0000_9999;
      mem_rd    = 5'd12;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (n_gnt - base >= 2) break;
      end
      chk("rst_two_granted", 64'(n_gnt - base), 64'd2);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("midrst_mc_req", mc_req, 1'b0);
      chk("midrst_mc_addr", mc_addr, 32'h0);
      chk("midrst_stall", stall_req, 1'b0);
      chk("midrst_wb", {wb_wreg, wb_wdata}, 33'h0);
      mem_sel   = 2'd0;
      mem_wdata = 32'h0BAD_CAFE;
      xq.delete();
      r.due  = cyc + 2;
      r.data = 8'hA5;
      rq.push_back(r);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("postrst_nop_wb", wb_wdata, 32'h0BAD_CAFE);
         chk("postrst_nop_stall", stall_req, 1'b0);
         chk("postrst_nop_req", mc_req, 1'b0);
      end
      chk("postrst_late_rvalid_sent", 64'(rq.size()), 64'd0);

      mem[32'h0000_9000] = 8'h7F;
      run_op("ldb_postrst", 2'd1, 1'b0, 1'b1, 32'h0000_9000, 32'h0, 32'hAAAA_0009, 5'd13, 0, 1, 0, 3, 32'h0000_007F);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
